// File: rtl/branch_stack_if.sv
// Dispatch/resolve/retire bundle between the rename stage and the branch checkpoint stack.
// The slave side is the checkpoint stack; the master side is the pipeline that drives it.
interface branch_stack_if #(
    parameter int DEPTH       = 4,
    parameter int PHYS_REG_SZ = 64,
    parameter int N           = 2
);
    localparam int NUM_SCALAR_BITS = $clog2(N + 1);
    localparam int IDX_W           = $clog2(PHYS_REG_SZ);
    localparam int TAG_W           = $clog2(DEPTH);

    logic                            push_valid;
    logic [PHYS_REG_SZ-1:0]          push_free_list;
    logic [TAG_W-1:0]                push_idx;
    logic                            full;
    logic                            resolve_valid;
    logic [TAG_W-1:0]                resolve_idx;
    logic                            resolve_mispredict;
    logic [N-1:0][IDX_W-1:0]         phys_regs_retiring;
    logic [NUM_SCALAR_BITS-1:0]      num_retiring_valid;
    logic [PHYS_REG_SZ-1:0]          free_list_restore;
    logic                            restore_flag;

    modport master (
        output push_valid, push_free_list, resolve_valid, resolve_idx, resolve_mispredict,
               phys_regs_retiring, num_retiring_valid,
        input  push_idx, full, free_list_restore, restore_flag
    );

    modport slave (
        input  push_valid, push_free_list, resolve_valid, resolve_idx, resolve_mispredict,
               phys_regs_retiring, num_retiring_valid,
        output push_idx, full, free_list_restore, restore_flag
    );
endinterface

// File: rtl/branch_stack.sv
// Circular stack of free-list checkpoints, one per in-flight branch.
// A mispredict restores the branch's snapshot and squashes it along with every younger checkpoint.
module branch_stack #(
    parameter int DEPTH       = 4,
    parameter int PHYS_REG_SZ = 64,
    parameter int N           = 2
) (
    input  logic            clock,
    input  logic            reset,
    branch_stack_if.slave   bs
);
    localparam int NUM_SCALAR_BITS = $clog2(N + 1);
    localparam int TAG_W           = $clog2(DEPTH);
    localparam int CNT_W           = TAG_W + 1;

    logic [DEPTH-1:0]       valid_q, valid_d;
    logic [PHYS_REG_SZ-1:0] snap_q [DEPTH];
    logic [PHYS_REG_SZ-1:0] snap_d [DEPTH];
    logic [TAG_W-1:0]       head_q, head_d;
    logic [TAG_W-1:0]       tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   restore_flag_q, restore_flag_d;
    logic [PHYS_REG_SZ-1:0] restore_q, restore_d;

    logic [PHYS_REG_SZ-1:0] retire_mask;
    logic                   full;
    logic                   resolve_hit;
    logic                   mispredict_hit;
    logic                   push_accept;
    logic                   reclaim;
    logic [TAG_W-1:0]       squash_diff;
    logic [CNT_W-1:0]       squash_span;

    // Register 0 is hard-wired and must never reappear as free.
    always_comb begin
        retire_mask = '0;
        for (int i = 0; i < N; i++) begin
            if (NUM_SCALAR_BITS'(i) < bs.num_retiring_valid) begin
                retire_mask[bs.phys_regs_retiring[i]] = 1'b1;
            end
        end
        retire_mask[0] = 1'b0;
    end

    assign full           = (count_q == CNT_W'(DEPTH));
    assign resolve_hit    = bs.resolve_valid & valid_q[bs.resolve_idx];
    assign mispredict_hit = resolve_hit & bs.resolve_mispredict;
    assign push_accept    = bs.push_valid & ~full & ~(bs.resolve_valid & bs.resolve_mispredict);
    assign reclaim        = (count_q != '0) & ~valid_q[head_q] & ~mispredict_hit;

    // A valid entry at the tail can only mean the stack is full, so a zero distance spans all entries.
    assign squash_diff = tail_q - bs.resolve_idx;
    assign squash_span = (squash_diff == '0) ? CNT_W'(DEPTH) : {1'b0, squash_diff};

    always_comb begin
        logic [TAG_W-1:0] age_off;
        valid_d        = valid_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        restore_flag_d = 1'b0;
        restore_d      = '0;
        age_off        = '0;

        for (int k = 0; k < DEPTH; k++) begin
            snap_d[k] = valid_q[k] ? (snap_q[k] | retire_mask) : snap_q[k];
        end

        if (resolve_hit && !bs.resolve_mispredict) begin
            valid_d[bs.resolve_idx] = 1'b0;
        end

        if (mispredict_hit) begin
            restore_flag_d = 1'b1;
            restore_d      = snap_q[bs.resolve_idx] | retire_mask;
            for (int k = 0; k < DEPTH; k++) begin
                age_off = TAG_W'(k) - bs.resolve_idx;
                if ({1'b0, age_off} < squash_span) begin
                    valid_d[k] = 1'b0;
                end
            end
            tail_d  = bs.resolve_idx;
            count_d = {1'b0, bs.resolve_idx - head_q};
        end

        if (push_accept) begin
            valid_d[tail_q] = 1'b1;
            snap_d[tail_q]  = bs.push_free_list | retire_mask;
            tail_d          = tail_q + TAG_W'(1);
        end

        if (reclaim) begin
            head_d = head_q + TAG_W'(1);
        end

        if (push_accept && !reclaim) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_accept && reclaim) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q        <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            restore_flag_q <= 1'b0;
            restore_q      <= '0;
        end else begin
            valid_q        <= valid_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            restore_flag_q <= restore_flag_d;
            restore_q      <= restore_d;
        end
    end

    // Snapshot contents are don't-care while their valid bit is clear, so they skip reset.
    always_ff @(posedge clock) begin
        for (int k = 0; k < DEPTH; k++) begin
            snap_q[k] <= snap_d[k];
        end
    end

    assign bs.push_idx          = tail_q;
    assign bs.full              = full;
    assign bs.restore_flag      = restore_flag_q;
    assign bs.free_list_restore = restore_q;
endmodule

// File: tb/tb_branch_stack.sv
// Directed and random stimulus for branch_stack, checked against an age-ordered queue model
// of outstanding checkpoints.
module tb_branch_stack;
    localparam int DEPTH = 4;
    localparam int PHYS  = 64;
    localparam int N     = 2;
    localparam int IDX_W = 6;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    branch_stack_if #(.DEPTH(DEPTH), .PHYS_REG_SZ(PHYS), .N(N)) bus ();

    branch_stack #(.DEPTH(DEPTH), .PHYS_REG_SZ(PHYS), .N(N)) dut (
        .clock (clock),
        .reset (reset),
        .bs    (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: allocated checkpoints oldest-first, each with its tag, valid bit and snapshot.
    int            m_tag  [$];
    bit            m_val  [$];
    logic [PHYS-1:0] m_snap [$];
    int            m_head  = 0;
    bit            m_rflag = 1'b0;
    logic [PHYS-1:0] m_rvec = '0;

    function automatic logic [PHYS-1:0] retireSet(int r0, int r1, int nret);
        logic [PHYS-1:0] s;
        int regs [2];
        s = '0;
        regs[0] = r0;
        regs[1] = r1;
        for (int i = 0; i < N; i++) begin
            if (i < nret && regs[i] != 0) s[regs[i]] = 1'b1;
        end
        return s;
    endfunction

    task automatic modelStep(bit rst_n, bit pv, logic [PHYS-1:0] pfl, bit rv, int ridx, bit rm,
                             logic [PHYS-1:0] rset);
        int pos;
        bit hit, mp, do_push, do_pop;
        int new_tag;
        if (!rst_n) begin
            m_tag.delete();
            m_val.delete();
            m_snap.delete();
            m_head  = 0;
            m_rflag = 1'b0;
            m_rvec  = '0;
            return;
        end
        pos = -1;
        for (int i = 0; i < m_tag.size(); i++) if (m_tag[i] == ridx) pos = i;
        hit     = rv && (pos >= 0) && m_val[pos];
        mp      = hit && rm;
        do_push = pv && (m_tag.size() < DEPTH) && !(rv && rm);
        do_pop  = (m_tag.size() > 0) && !m_val[0] && !mp;
        new_tag = (m_head + m_tag.size()) % DEPTH;

        m_rflag = 1'b0;
        m_rvec  = '0;
        for (int i = 0; i < m_tag.size(); i++) if (m_val[i]) m_snap[i] = m_snap[i] | rset;
        if (hit && !rm) m_val[pos] = 1'b0;
        if (mp) begin
            m_rflag = 1'b1;
            m_rvec  = m_snap[pos];
            while (m_tag.size() > pos) begin
                void'(m_tag.pop_back());
                void'(m_val.pop_back());
                void'(m_snap.pop_back());
            end
        end
        if (do_push) begin
            m_tag.push_back(new_tag);
            m_val.push_back(1'b1);
            m_snap.push_back(pfl | rset);
        end
        if (do_pop) begin
            void'(m_tag.pop_front());
            void'(m_val.pop_front());
            void'(m_snap.pop_front());
            m_head = (m_head + 1) % DEPTH;
        end
    endtask

    task automatic checkValue(string tag, logic [PHYS-1:0] observed, logic [PHYS-1:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        checkValue("push_idx", PHYS'(bus.push_idx), PHYS'((m_head + m_tag.size()) % DEPTH));
        checkValue("full", PHYS'(bus.full), PHYS'(m_tag.size() == DEPTH));
        checkValue("restore_flag", PHYS'(bus.restore_flag), PHYS'(m_rflag));
        checkValue("free_list_restore", bus.free_list_restore, m_rvec);
    endtask

    task automatic applyStimulus(bit rst_n, bit pv, logic [PHYS-1:0] pfl, bit rv, int ridx, bit rm,
                                 int r0, int r1, int nret);
        @(negedge clock);
        reset                     = rst_n;
        bus.push_valid            = pv;
        bus.push_free_list        = pfl;
        bus.resolve_valid         = rv;
        bus.resolve_idx           = 2'(ridx);
        bus.resolve_mispredict    = rm;
        bus.phys_regs_retiring[0] = IDX_W'(r0);
        bus.phys_regs_retiring[1] = IDX_W'(r1);
        bus.num_retiring_valid    = 2'(nret);
        modelStep(rst_n, pv, pfl, rv, ridx, rm, retireSet(r0, r1, nret));
        @(posedge clock);
        #1;
        checkOutput();
    endtask

    task automatic doPush(logic [PHYS-1:0] fl);
        applyStimulus(1, 1, fl, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doResolve(int idx, bit mp);
        applyStimulus(1, 0, '0, 1, idx, mp, 0, 0, 0);
    endtask

    task automatic doIdle();
        applyStimulus(1, 0, '0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        applyStimulus(0, 0, '0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit pv, rv, rm, rst_n;
        int ridx;

        reset                  = 1'b0;
        bus.push_valid         = 1'b0;
        bus.push_free_list     = '0;
        bus.resolve_valid      = 1'b0;
        bus.resolve_idx        = '0;
        bus.resolve_mispredict = 1'b0;
        bus.phys_regs_retiring = '0;
        bus.num_retiring_valid = '0;

        doReset();
        doReset();
        checkValue("rst_push_idx", PHYS'(bus.push_idx), 0);
        checkValue("rst_full", PHYS'(bus.full), 0);
        checkValue("rst_restore_flag", PHYS'(bus.restore_flag), 0);

        // Push then immediate mispredict of the same checkpoint.
        doPush(64'hF0);
        checkValue("one_push_idx", PHYS'(bus.push_idx), 1);
        doResolve(0, 1);
        checkValue("mp0_flag", PHYS'(bus.restore_flag), 1);
        checkValue("mp0_vec", bus.free_list_restore, 64'hF0);
        checkValue("mp0_tail", PHYS'(bus.push_idx), 0);
        doIdle();
        checkValue("mp0_pulse_end", PHYS'(bus.restore_flag), 0);
        checkValue("mp0_vec_clear", bus.free_list_restore, 0);

        // Fill, overfill, then free the oldest by correct resolve.
        for (int i = 0; i < 4; i++) doPush(64'(i + 1) << 8);
        checkValue("fill_full", PHYS'(bus.full), 1);
        doPush(64'hDEAD);
        checkValue("overfill_full", PHYS'(bus.full), 1);
        checkValue("overfill_idx", PHYS'(bus.push_idx), 0);
        doResolve(0, 0);
        checkValue("resolve_still_full", PHYS'(bus.full), 1);
        doIdle();
        checkValue("reclaim_not_full", PHYS'(bus.full), 0);

        // Mispredict of a middle checkpoint beats a simultaneous push.
        doReset();
        for (int i = 0; i < 4; i++) doPush(64'h11 << i);
        applyStimulus(1, 1, 64'hABCD, 1, 2, 1, 0, 0, 0);
        checkValue("mid_mp_flag", PHYS'(bus.restore_flag), 1);
        checkValue("mid_mp_vec", bus.free_list_restore, 64'h44);
        checkValue("mid_mp_tail", PHYS'(bus.push_idx), 2);
        doResolve(3, 1);
        checkValue("squashed3_no_restore", PHYS'(bus.restore_flag), 0);
        checkValue("squashed3_tail", PHYS'(bus.push_idx), 2);
        doResolve(2, 1);
        checkValue("squashed2_no_restore", PHYS'(bus.restore_flag), 0);
        doPush(64'h1);
        checkValue("refill_not_full", PHYS'(bus.full), 0);
        doPush(64'h2);
        checkValue("refill_full", PHYS'(bus.full), 1);

        // Retired registers merge into a live snapshot; register 0 never does.
        doReset();
        doPush(64'h3);
        doPush(64'h0);
        doIdle();
        applyStimulus(1, 0, '0, 0, 0, 0, 5, 0, 2);
        doResolve(1, 1);
        checkValue("retire_merge_vec", bus.free_list_restore, 64'h20);
        checkValue("retire_merge_flag", PHYS'(bus.restore_flag), 1);

        // Reset wins over a pending mispredict and push.
        doPush(64'h7);
        applyStimulus(0, 1, 64'hFF, 1, 0, 1, 9, 10, 2);
        checkValue("rst_mp_flag", PHYS'(bus.restore_flag), 0);
        checkValue("rst_mp_full", PHYS'(bus.full), 0);
        checkValue("rst_mp_idx", PHYS'(bus.push_idx), 0);
        for (int i = 0; i < 3; i++) doPush(64'h100);
        checkValue("post_rst_three", PHYS'(bus.full), 0);
        doPush(64'h200);
        checkValue("post_rst_four", PHYS'(bus.full), 1);

        // Random traffic with resolves biased toward live checkpoints.
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            pv    = ($urandom_range(0, 9) < 6);
            rv    = ($urandom_range(0, 9) < 4);
            rm    = ($urandom_range(0, 9) < 3);
            if (m_tag.size() > 0 && $urandom_range(0, 9) < 7)
                ridx = m_tag[$urandom_range(0, m_tag.size() - 1)];
            else
                ridx = $urandom_range(0, DEPTH - 1);
            applyStimulus(rst_n, pv, {$urandom, $urandom}, rv, ridx, rm,
                          $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_stack.md
BRANCH_STACK -- requirements
Module: branch_stack

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of branch checkpoints (power of two, >=2).
REQ-002 SHALL have parameter PHYS_REG_SZ, default 64: physical register count, i.e. free-list vector width.
REQ-003 SHALL have parameter N, default 2: retire width; NUM_SCALAR_BITS = $clog2(N+1), IDX_W = $clog2(PHYS_REG_SZ), TAG_W = $clog2(DEPTH).
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-006 SHALL have port push_valid  input  1  dispatch requests a checkpoint for one branch.
REQ-007 SHALL have port push_free_list  input  PHYS_REG_SZ  dispatch's free list after this cycle's allocations.
REQ-008 SHALL have port push_idx  output  TAG_W  checkpoint index allocated on push (= tail).
REQ-009 SHALL have port full  output  1  no checkpoint available; push is not accepted.
REQ-010 SHALL have port resolve_valid  input  1  a branch resolves this cycle.
REQ-011 SHALL have port resolve_idx  input  TAG_W  checkpoint index of the resolving branch.
REQ-012 SHALL have port resolve_mispredict  input  1  resolving branch mispredicted.
REQ-013 SHALL have port phys_regs_retiring  input  N x IDX_W  T_old registers freed by retire.
REQ-014 SHALL have port num_retiring_valid  input  NUM_SCALAR_BITS  count of valid phys_regs_retiring entries, lowest-first.
REQ-015 SHALL have port free_list_restore  output  PHYS_REG_SZ  snapshot for the free list on mispredict.
REQ-016 SHALL have port restore_flag  output  1  free_list_restore valid; free list must load it.

Function
REQ-017 SHALL hold per entry: valid bit, snapshot vector; plus head, tail (TAG_W, wrap mod DEPTH) and count (0..DEPTH).
REQ-018 SHALL drive push_idx = tail and full = (count == DEPTH) combinationally from registered state.
REQ-019 SHALL build retire mask R each cycle: bit phys_regs_retiring[i] set for i < num_retiring_valid; index 0 never set.
REQ-020 SHALL OR R into the snapshot of every valid entry each cycle.
REQ-021 SHALL accept a push when push_valid & ~full & ~(resolve_valid & resolve_mispredict): entry[tail] <= {valid=1, push_free_list | R}; tail+1; count+1.
REQ-022 SHALL, on resolve_valid & ~resolve_mispredict with entry[resolve_idx] valid, clear that valid bit next cycle.
REQ-023 SHALL, on resolve_valid & resolve_mispredict with entry[resolve_idx] valid: next cycle restore_flag=1, free_list_restore = snapshot[resolve_idx] | R.
REQ-024 SHALL, on that mispredict, invalidate resolve_idx and all younger entries up to tail-1, set tail = resolve_idx, count = (resolve_idx - head) mod DEPTH.
REQ-025 SHALL ignore any resolve targeting an invalid entry (no state change, no restore).
REQ-026 SHALL reclaim one entry per cycle: if count>0, ~valid[head], no mispredict this cycle -> head+1, count-1; push in same cycle leaves count net unchanged.
REQ-027 SHALL drive restore_flag=0 and free_list_restore=0 in every cycle not following an accepted mispredict (one-cycle pulse).
REQ-028 SHALL keep count correct across wrap-around of head/tail; full blocks push even if reclaim occurs that cycle (full is pre-update).

Reset
REQ-029 SHALL, while reset==0 at posedge, clear all valid bits, head=tail=0, count=0, restore_flag=0, free_list_restore=0; snapshots need not be cleared.
REQ-030 SHALL make reset override push, resolve, and retire in the same cycle; full=0, push_idx=0 in the first cycle after reset.

Verification (DEPTH=4, PHYS_REG_SZ=64, N=2)
REQ-031 SHALL cover: push free_list=0xF0 at idx0, mispredict idx0 next cycle -> following cycle restore_flag=1, free_list_restore=0xF0, count=0, tail=0.
REQ-032 SHALL cover: push 4 branches -> full=1; 5th push ignored, push_idx stays 0; resolve idx0 correct -> reclaim next cycle, full=0.
REQ-033 SHALL cover: push 0x00 at idx1, retire regs {5,0} (num=2) two cycles later, mispredict idx1 -> restore = 0x20 (bit 0 stays clear).
REQ-034 SHALL cover: entries 0..3 valid, mispredict idx2 with push_valid=1 same cycle -> push rejected, tail=2, count=2, entries 2,3 invalid.
REQ-035 SHALL cover: resolve_idx on invalid entry with mispredict=1 -> restore_flag stays 0, no state change.
REQ-036 SHALL cover: reset=0 asserted mid-stack with mispredict pending -> next cycle restore_flag=0, count=0, full=0.
